bf16_add_arbiter: RTL and testbench

BF16_ADD_ARBITER -- requirements
Module: bf16_add_arbiter

---
 rtl/bf16_add_arbiter_if.sv | 53 +++++
 rtl/bf16_add_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bf16_add_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// bf16_add_arbiter_if
// Bundles the requester, result and adder-side handshake signals of
// bf16_add_arbiter. Signal names match the arbiter's ports one-for-one, so an
// environment can wire a single interface instance straight onto the module.
//
//   master : the environment view (requesters, result consumers, adder)
//   slave  : the arbiter view
//
// Signals:
//   req_stb/req_a/req_b/req_busy   requester operand handshake (N_REQ lanes)
//   rsp_sum/rsp_stb/rsp_busy       shared result bus, per-requester strobes
//   adder_a/adder_b/adder_input_STB/adder_BUSY          adder input handshake
//   adder_sum/adder_output_STB/output_module_BUSY       adder output handshake
//   adder_rst                      active-high reset to the adder
//   op_count                       completed-operation counter
// ---------------------------------------------------------------------------
interface bf16_add_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req_stb;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_busy;
    logic [15:0]         rsp_sum;
    logic [N_REQ-1:0]    rsp_stb;
    logic [N_REQ-1:0]    rsp_busy;
    logic [15:0]         adder_a;
    logic [15:0]         adder_b;
    logic                adder_input_STB;
    logic                adder_BUSY;
    logic [15:0]         adder_sum;
    logic                adder_output_STB;
    logic                output_module_BUSY;
    logic                adder_rst;
    logic [15:0]         op_count;

    modport master (
        output req_stb, req_a, req_b, rsp_busy,
               adder_BUSY, adder_sum, adder_output_STB,
        input  req_busy, rsp_sum, rsp_stb,
               adder_a, adder_b, adder_input_STB,
               output_module_BUSY, adder_rst, op_count
    );

    modport slave (
        input  req_stb, req_a, req_b, rsp_busy,
               adder_BUSY, adder_sum, adder_output_STB,
        output req_busy, rsp_sum, rsp_stb,
               adder_a, adder_b, adder_input_STB,
               output_module_BUSY, adder_rst, op_count
    );
endinterface

// File: rtl/bf16_add_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_add_arbiter
// Shares one bf16 adder between N_REQ requesters. A round-robin winner is
// chosen in IDLE, its operands are latched and handed to the adder, the sum is
// captured and then delivered back to the same requester. At most one
// operation is in flight; no new grant is given until the current result has
// been accepted by its consumer.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_stb  [N_REQ]            per-requester operand-valid strobe
//   req_a/req_b [16*N_REQ]      packed bf16 operands, lane i at [16i+15:16i]
//   req_busy [N_REQ]            low on the lane whose operands are taken
//   rsp_sum  [16]               shared result, holds the last delivered value
//   rsp_stb  [N_REQ]            one-hot result strobe (or zero)
//   rsp_busy [N_REQ]            per-requester result-consumer busy
//   adder_a/adder_b [16]        operands to the adder
//   adder_input_STB/adder_BUSY  adder input handshake
//   adder_sum [16], adder_output_STB, output_module_BUSY  adder output handshake
//   adder_rst                   active-high adder reset, released 2 edges late
//   op_count [16]               completed operations, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module bf16_add_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N_REQ-1:0]    req_stb,
    input  logic [16*N_REQ-1:0] req_a,
    input  logic [16*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_busy,
    output logic [15:0]         rsp_sum,
    output logic [N_REQ-1:0]    rsp_stb,
    input  logic [N_REQ-1:0]    rsp_busy,
    output logic [15:0]         adder_a,
    output logic [15:0]         adder_b,
    output logic                adder_input_STB,
    input  logic                adder_BUSY,
    input  logic [15:0]         adder_sum,
    input  logic                adder_output_STB,
    output logic                output_module_BUSY,
    output logic                adder_rst,
    output logic [15:0]         op_count
);

    localparam int unsigned IDXW = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_rr_ptr;
    logic [IDXW-1:0] r_idx;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic [15:0]     r_result;
    logic [15:0]     r_op_count;
    logic [1:0]      r_rst_sync;

    logic            w_ready;
    logic            w_found;
    logic [IDXW-1:0] w_win;
    logic [IDXW-1:0] w_j;
    logic            w_grant;
    logic [15:0]     w_a;
    logic [15:0]     w_b;

    // Reset release shifter: the adder leaves reset, and grants become
    // possible, on the second rising edge after resetn goes high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_ready   = r_rst_sync[1];
    assign adder_rst = ~r_rst_sync[1];

    // Round-robin search: first set strobe starting just above the last
    // served requester, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_j = IDXW'((32'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req_stb[w_j]) begin
                w_found = 1'b1;
                w_win   = w_j;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_ready && w_found;

    // Winner operand mux.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win == IDXW'(i)) begin
                w_a = req_a[i*16 +: 16];
                w_b = req_b[i*16 +: 16];
            end
        end
    end

    // Main sequencer: one operation in flight, IDLE -> ISSUE -> WAIT -> DELIVER.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= IDXW'(N_REQ - 1);
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_idx   <= w_win;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!adder_BUSY) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Result strobes in any other state are not ours to take.
                    if (adder_output_STB) begin
                        r_result <= adder_sum;
                        r_state  <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (!rsp_busy[r_idx]) begin
                        r_rr_ptr   <= r_idx;
                        r_op_count <= r_op_count + 16'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_busy = '1;
        if (w_grant) begin
            req_busy[w_win] = 1'b0;
        end
    end

    always_comb begin
        rsp_stb = '0;
        if (r_state == S_DELIVER) begin
            rsp_stb[r_idx] = 1'b1;
        end
    end

    // r_result is only rewritten on the edge that enters DELIVER, so outside
    // DELIVER it still carries the last delivered sum.
    assign rsp_sum            = r_result;
    assign adder_a            = r_a;
    assign adder_b            = r_b;
    assign adder_input_STB    = (r_state == S_ISSUE);
    assign output_module_BUSY = (r_state != S_WAIT);
    assign op_count           = r_op_count;

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bf16_add_arbiter
// Directed bench for bf16_add_arbiter: a single-slot adder model with a
// programmable latency and stall, a result monitor, and hand-computed bf16
// sums for each requester's operand pair.
// ---------------------------------------------------------------------------
module tb_bf16_add_arbiter;

    localparam int unsigned N = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    bf16_add_arbiter_if #(.N_REQ(N)) bus();

    bf16_add_arbiter #(.N_REQ(N)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .req_stb            (bus.req_stb),
        .req_a              (bus.req_a),
        .req_b              (bus.req_b),
        .req_busy           (bus.req_busy),
        .rsp_sum            (bus.rsp_sum),
        .rsp_stb            (bus.rsp_stb),
        .rsp_busy           (bus.rsp_busy),
        .adder_a            (bus.adder_a),
        .adder_b            (bus.adder_b),
        .adder_input_STB    (bus.adder_input_STB),
        .adder_BUSY         (bus.adder_BUSY),
        .adder_sum          (bus.adder_sum),
        .adder_output_STB   (bus.adder_output_STB),
        .output_module_BUSY (bus.output_module_BUSY),
        .adder_rst          (bus.adder_rst),
        .op_count           (bus.op_count)
    );

    // Operand pairs per requester and their hand-computed bf16 sums:
    // 1.0+2.0=3.0, 2.0+2.0=4.0, 5.0+1.0=6.0, 0.5+0.5=1.0
    logic [15:0] VA [4] = '{16'h3F80, 16'h4000, 16'h40A0, 16'h3F00};
    logic [15:0] VB [4] = '{16'h4000, 16'h4000, 16'h3F80, 16'h3F00};
    logic [15:0] VS [4] = '{16'h4040, 16'h4080, 16'h40C0, 16'h3F80};

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- adder model: one slot, latency 'lat' ----------------
    logic        busy_hold = 1'b0;
    int unsigned lat       = 1;
    logic        pend      = 1'b0;
    int unsigned cnt       = 0;
    logic [15:0] p_sum     = '0;
    int unsigned n_xfer    = 0;

    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        model_sum = 16'h7FC0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (a == VA[k] && b == VB[k]) model_sum = VS[k];
        end
    endfunction

    assign bus.adder_BUSY       = busy_hold | pend;
    assign bus.adder_output_STB = pend && (cnt == 0);
    assign bus.adder_sum        = p_sum;

    always @(posedge clk or posedge bus.adder_rst) begin
        if (bus.adder_rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            p_sum <= '0;
        end else if (pend) begin
            if (bus.adder_output_STB && !bus.output_module_BUSY) pend <= 1'b0;
            else if (cnt != 0) cnt <= cnt - 1;
        end else if (bus.adder_input_STB && !bus.adder_BUSY) begin
            pend   <= 1'b1;
            cnt    <= lat;
            p_sum  <= model_sum(bus.adder_a, bus.adder_b);
            n_xfer <= n_xfer + 1;
        end
    end

    // ---------------- result monitor ----------------
    typedef struct packed {
        logic [31:0] idx;
        logic [15:0] sum;
    } dlv_t;

    dlv_t        dq[$];
    int unsigned onehot_err = 0;

    always @(posedge clk) begin
        if (bus.rsp_stb != '0) begin
            if (!$onehot(bus.rsp_stb)) onehot_err <= onehot_err + 1;
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.rsp_stb[i] && !bus.rsp_busy[i]) dq.push_back('{idx: i, sum: bus.rsp_sum});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_dlv(input int unsigned n, input string tag);
        for (int unsigned k = 0; k < 200 && dq.size() < n; k++) @(negedge clk);
        chk({tag, "_dlv"}, 32'(dq.size()), 32'(n));
    endtask

    task automatic pop_chk(input string tag, input int unsigned idx, input logic [15:0] sum);
        dlv_t d;
        if (dq.size() == 0) begin
            chk({tag, "_empty"}, 32'(dq.size()), 32'd1);
        end else begin
            d = dq.pop_front();
            chk({tag, "_idx"}, d.idx, 32'(idx));
            chk({tag, "_sum"}, 32'(d.sum), 32'(sum));
        end
    endtask

    // Raise one strobe, hold it until the grant edge, then drop it.
    task automatic issue(input int unsigned i, input string tag);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        bus.req_stb[i] = 1'b1;
        for (int unsigned k = 0; k < 100 && !ok; k++) begin
            #1;
            if (!bus.req_busy[i]) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_stb[i] = 1'b0;
        chk({tag, "_grant"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned x0;
        bus.req_stb  = '1;
        bus.req_a    = {VA[3], VA[2], VA[1], VA[0]};
        bus.req_b    = {VB[3], VB[2], VB[1], VB[0]};
        bus.rsp_busy = '0;
        #1 resetn = 1'b0;

        // ---- reset state, all strobes already high ----
        @(negedge clk);
        chk("rst_req_busy",  32'(bus.req_busy), 32'hF);
        chk("rst_rsp_stb",   32'(bus.rsp_stb), 32'h0);
        chk("rst_in_stb",    32'(bus.adder_input_STB), 32'd0);
        chk("rst_omb",       32'(bus.output_module_BUSY), 32'd1);
        chk("rst_adder_rst", 32'(bus.adder_rst), 32'd1);
        chk("rst_op_count",  32'(bus.op_count), 32'd0);
        chk("rst_rsp_sum",   32'(bus.rsp_sum), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel1_adder_rst", 32'(bus.adder_rst), 32'd1);
        chk("rel1_req_busy",  32'(bus.req_busy), 32'hF);
        @(negedge clk);
        chk("rel2_adder_rst", 32'(bus.adder_rst), 32'd0);
        chk("rel2_req_busy",  32'(bus.req_busy), 32'hE);

        // ---- round robin with all four requesting: 0,1,2,3,0 ----
        wait_dlv(5, "rr");
        bus.req_stb = '0;
        pop_chk("rr0", 0, VS[0]);
        pop_chk("rr1", 1, VS[1]);
        pop_chk("rr2", 2, VS[2]);
        pop_chk("rr3", 3, VS[3]);
        pop_chk("rr4", 0, VS[0]);
        chk("rr_op_count", 32'(bus.op_count), 32'd5);

        // ---- single request, 1.0 + 2.0 ----
        issue(0, "single");
        wait_dlv(1, "single");
        pop_chk("single", 0, 16'h4040);
        chk("single_op_count", 32'(bus.op_count), 32'd6);
        chk("single_stb_end",  32'(bus.rsp_stb), 32'h0);
        chk("single_sum_hold", 32'(bus.rsp_sum), 32'h4040);

        // ---- strobe withdrawn before the edge: no capture ----
        x0 = n_xfer;
        @(negedge clk);
        bus.req_stb[1] = 1'b1;
        #2 bus.req_stb[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("wd_in_stb",   32'(bus.adder_input_STB), 32'd0);
        chk("wd_req_busy", 32'(bus.req_busy), 32'hF);
        @(negedge clk);
        chk("wd_xfer",     n_xfer, x0);

        // ---- adder stalls for 5 cycles in ISSUE ----
        busy_hold = 1'b1;
        x0 = n_xfer;
        issue(2, "stall");
        for (int unsigned k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_stb", 32'(bus.adder_input_STB), 32'd1);
            chk("stall_a",      32'(bus.adder_a), 32'(VA[2]));
            chk("stall_b",      32'(bus.adder_b), 32'(VB[2]));
            @(negedge clk);
        end
        busy_hold = 1'b0;
        wait_dlv(1, "stall");
        pop_chk("stall", 2, 16'h40C0);
        chk("stall_xfer", n_xfer, x0 + 1);

        // ---- consumer 2 busy for 10 cycles in DELIVER, 0 waiting ----
        bus.rsp_busy[2] = 1'b1;
        issue(2, "hold");
        for (int unsigned k = 0; k < 100 && !bus.rsp_stb[2]; k++) begin
            @(negedge clk);
            #1;
        end
        chk("hold_reach", 32'(bus.rsp_stb), 32'h4);
        bus.req_stb[0] = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_stb",  32'(bus.rsp_stb), 32'h4);
            chk("hold_rsp_sum",  32'(bus.rsp_sum), 32'(VS[2]));
            chk("hold_req_busy", 32'(bus.req_busy), 32'hF);
        end
        bus.rsp_busy[2] = 1'b0;
        wait_dlv(1, "hold");
        pop_chk("hold", 2, VS[2]);
        #1;
        chk("hold_next_grant", 32'(bus.req_busy), 32'hE);
        @(negedge clk);
        bus.req_stb[0] = 1'b0;
        wait_dlv(1, "hold_next");
        pop_chk("hold_next", 0, VS[0]);
        chk("hold_op_count", 32'(bus.op_count), 32'd9);

        // ---- reset pulse while waiting on the adder ----
        lat = 8;
        issue(3, "rstop");
        for (int unsigned k = 0; k < 50 && bus.output_module_BUSY; k++) @(negedge clk);
        chk("rstop_wait", 32'(bus.output_module_BUSY), 32'd0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rstop_req_busy",  32'(bus.req_busy), 32'hF);
        chk("rstop_omb",       32'(bus.output_module_BUSY), 32'd1);
        chk("rstop_in_stb",    32'(bus.adder_input_STB), 32'd0);
        chk("rstop_adder_rst", 32'(bus.adder_rst), 32'd1);
        chk("rstop_rsp_stb",   32'(bus.rsp_stb), 32'h0);
        chk("rstop_op_count",  32'(bus.op_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rstop_rel1", 32'(bus.adder_rst), 32'd1);
        @(negedge clk);
        chk("rstop_rel2", 32'(bus.adder_rst), 32'd0);
        lat = 1;
        repeat (12) @(negedge clk);
        chk("rstop_no_dlv", 32'(dq.size()), 32'd0);
        issue(3, "reissue");
        wait_dlv(1, "reissue");
        pop_chk("reissue", 3, VS[3]);
        chk("reissue_op_count", 32'(bus.op_count), 32'd1);

        // ---- op_count wrap, counter preloaded near the top ----
        @(negedge clk);
        force dut.r_op_count = 16'hFFFE;
        #1 release dut.r_op_count;
        issue(1, "wrap1");
        wait_dlv(1, "wrap1");
        pop_chk("wrap1", 1, VS[1]);
        chk("wrap1_op_count", 32'(bus.op_count), 32'hFFFF);
        issue(1, "wrap2");
        wait_dlv(1, "wrap2");
        pop_chk("wrap2", 1, VS[1]);
        chk("wrap2_op_count", 32'(bus.op_count), 32'h0);

        chk("onehot", onehot_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
